// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer: fetches one line word-by-word over req/gnt + rvalid,
// then writes it into the cache arrays in one cycle. Define ICACHE_CRITICAL_WORD_FIRST_EN for critical-word-first.
module icache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 4,
  parameter int CACHE_SIZE = 256
) (
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic                                                       miss,
  input  logic [ADDR_WIDTH-1:0]                                      miss_addr,
  input  logic                                                       flush,
  output logic                                                       stall,
  output logic                                                       mem_req,
  output logic [ADDR_WIDTH-1:0]                                      mem_addr,
  input  logic                                                       mem_gnt,
  input  logic                                                       mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                                      mem_rdata,
  output logic                                                       fill_we,
  output logic [$clog2(CACHE_SIZE)-1:0]                              fill_index,
  output logic [ADDR_WIDTH-$clog2(LINE_SIZE)-$clog2(CACHE_SIZE)-3:0] fill_tag,
  output logic [DATA_WIDTH*LINE_SIZE-1:0]                            fill_data
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  ,
  output logic                                                       crit_valid
`endif
);

  localparam int CW = $clog2(LINE_SIZE);
  localparam int OB = CW + 2;
  localparam int IB = $clog2(CACHE_SIZE);
  localparam int LW = ADDR_WIDTH - OB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t                         r_state;
  logic [CW-1:0]                  r_cnt;
  logic [CW-1:0]                  r_start;
  logic [LW-1:0]                  r_line;
  logic [DATA_WIDTH*LINE_SIZE-1:0] r_buf;
  logic                           r_mem_req;
  logic [ADDR_WIDTH-1:0]          r_mem_addr;
  logic                           r_fill_we;

  logic [CW-1:0]                  w_miss_start;
  logic [CW-1:0]                  w_word;
  logic [CW-1:0]                  w_next_word;
  logic                           w_unused_addr;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_miss_start = miss_addr[OB-1:2];
`else
  assign w_miss_start = '0;
`endif

  // Fetch order wraps around the line starting at r_start.
  assign w_word        = r_start + r_cnt;
  assign w_next_word   = w_word + 1'b1;
  assign w_unused_addr = ^miss_addr[OB-1:0];

  // NOTE: every register in this block uses <= so all state updates see the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_start    <= '0;
      r_line     <= '0;
      // NOTE: the line buffer is reset on purpose so fill_data reads zero out of reset.
      r_buf      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_fill_we  <= 1'b0;
    end else begin
      r_fill_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss && !flush) begin
            r_line     <= miss_addr[ADDR_WIDTH-1:OB];
            r_start    <= w_miss_start;
            r_cnt      <= '0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {miss_addr[ADDR_WIDTH-1:OB], w_miss_start, 2'b00};
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // A grant beats a simultaneous flush: the word is owed to us and must be drained.
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= flush ? S_DRAIN : S_WAIT;
          end else if (flush) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_buf[int'(w_word)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
              if (r_cnt == CW'(LINE_SIZE - 1)) begin
                r_fill_we <= 1'b1;
                r_state   <= S_FILL;
              end else begin
                r_cnt      <= r_cnt + 1'b1;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {r_line, w_next_word, 2'b00};
                r_state    <= S_REQ;
              end
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_FILL: r_state <= S_IDLE;
        S_DRAIN: begin
          if (mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall      = miss | (r_state != S_IDLE);
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign fill_we    = r_fill_we;
  assign fill_index = r_line[IB-1:0];
  assign fill_tag   = r_line[LW-1:IB];
  assign fill_data  = r_buf;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  // Must coincide with the rvalid beat itself, so it cannot be registered.
  assign crit_valid = (r_state == S_WAIT) && mem_rvalid && !flush && (r_cnt == '0);
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: cycle vectors for refills plus hand sequences
// for flush, drain and asynchronous reset corners.
module tb_icache_refill_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LS = 4;
  localparam int CS = 256;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          miss;
  logic [31:0]   miss_addr;
  logic          flush;
  logic          stall;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          fill_we;
  logic [7:0]    fill_index;
  logic [19:0]   fill_tag;
  logic [127:0]  fill_data;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic          crit_valid;
`endif

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .CACHE_SIZE(CS)
  ) dut (
    .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr), .flush(flush),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fill_we(fill_we),
    .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data)
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    , .crit_valid(crit_valid)
`endif
  );

  typedef struct {
    int           test;
    logic         miss;
    logic [31:0]  addr;
    logic         flush;
    logic         gnt;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         e_stall;
    logic         e_req;
    logic         e_we;
    logic         e_crit;
    bit           chk_addr;
    logic [31:0]  e_addr;
    bit           chk_fill;
    logic [7:0]   e_idx;
    logic [19:0]  e_tag;
    logic [127:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected request address for the k-th request of a refill of address a.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
    logic [1:0] w;
    w = 2'(k);
    if (CWF) w = w + a[3:2];
    return {a[31:4], w, 2'b00};
  endfunction

  task automatic push_v(input int t, input logic m, input logic [31:0] a,
                        input logic fl, input logic g, input logic rv, input logic [31:0] rd,
                        input logic es, input logic er, input logic ew,
                        input bit ca, input logic [31:0] ea, input logic ec);
    vec_t v;
    v = '{default: '0};
    v.test = t;     v.miss = m;      v.addr = a;     v.flush = fl;
    v.gnt = g;      v.rvalid = rv;   v.rdata = rd;
    v.e_stall = es; v.e_req = er;    v.e_we = ew;    v.e_crit = ec;
    v.chk_addr = ca; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  // Complete refill of address a; word w returns data db+w. Request slow_k waits slow_n extra cycles for gnt.
  task automatic add_refill(input int t, input logic [31:0] a, input logic [31:0] db,
                            input logic [7:0] ei, input logic [19:0] et,
                            input int slow_k, input int slow_n, input bit tail_idle);
    vec_t         f;
    logic [127:0] line;
    logic [31:0]  ma;
    push_v(t, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < LS; k++) begin
      ma = exp_addr(a, k);
      if (k == slow_k)
        for (int d = 0; d < slow_n; d++)
          push_v(t, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, ma, 1'b0);
      push_v(t, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, ma, 1'b0);
      push_v(t, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, db + 32'(ma[3:2]), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,
             (k == 0));
    end
    for (int w = 0; w < LS; w++) line[w*32 +: 32] = db + 32'(w);
    f = '{default: '0};
    f.test = t; f.e_stall = 1'b1; f.e_we = 1'b1;
    f.chk_fill = 1'b1; f.e_idx = ei; f.e_tag = et; f.e_data = line;
    vecs.push_back(f);
    if (tail_idle)
      push_v(t, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic idle_inputs();
    miss = 1'b0; miss_addr = 32'h0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // Each vector: drive just after the rising edge, sample on the falling edge.
  task automatic run_vecs();
    string p;
    foreach (vecs[i]) begin
      miss = vecs[i].miss;     miss_addr = vecs[i].addr;  flush = vecs[i].flush;
      mem_gnt = vecs[i].gnt;   mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      p = $sformatf("t%0d v%0d", vecs[i].test, i);
      check({p, " stall"},   128'(stall),   128'(vecs[i].e_stall));
      check({p, " mem_req"}, 128'(mem_req), 128'(vecs[i].e_req));
      check({p, " fill_we"}, 128'(fill_we), 128'(vecs[i].e_we));
      if (vecs[i].chk_addr) check({p, " mem_addr"}, 128'(mem_addr), 128'(vecs[i].e_addr));
      if (vecs[i].chk_fill) begin
        check({p, " fill_index"}, 128'(fill_index), 128'(vecs[i].e_idx));
        check({p, " fill_tag"},   128'(fill_tag),   128'(vecs[i].e_tag));
        check({p, " fill_data"},  fill_data,        vecs[i].e_data);
      end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      check({p, " crit_valid"}, 128'(crit_valid), 128'(vecs[i].e_crit));
`endif
      @(posedge clk);
      #1;
    end
    vecs.delete();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    idle_inputs();
    #3;
    check("reset stall",      128'(stall),      128'(0));
    check("reset mem_req",    128'(mem_req),    128'(0));
    check("reset mem_addr",   128'(mem_addr),   128'(0));
    check("reset fill_we",    128'(fill_we),    128'(0));
    check("reset fill_index", 128'(fill_index), 128'(0));
    check("reset fill_tag",   128'(fill_tag),   128'(0));
    check("reset fill_data",  fill_data,        128'(0));
    #20 reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic refill, fill_we nine cycles after the miss.
    add_refill(1, 32'h0000_1238, 32'hA0, 8'h23, 20'h00001, -1, 0, 1'b1);
    run_vecs();

    // 2: second request waits three extra cycles for its grant.
    add_refill(2, 32'h0000_1230, 32'hD0, 8'h23, 20'h00001, 1, 3, 1'b1);
    run_vecs();

    // 3: flush while waiting for word 2, drain the late word, then a clean refill.
    a = 32'h0000_1230;
    push_v(3, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_v(3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, exp_addr(a, k), 1'b0);
      push_v(3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, (k == 0));
    end
    push_v(3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, exp_addr(a, 2), 1'b0);
    push_v(3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    add_refill(3, a, 32'hC0, 8'h23, 20'h00001, -1, 0, 1'b1);
    run_vecs();

    // 4a: flush coincident with grant goes through DRAIN.
    push_v(4, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, exp_addr(a, 0), 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    // 4b: flush in REQ without grant returns to IDLE; a stray rvalid there is ignored.
    push_v(4, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, exp_addr(a, 0), 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Flush in IDLE suppresses a new miss.
    push_v(4, 1'b1, a, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_vecs();

    // 5: asynchronous reset mid-WAIT of word 1.
    push_v(5, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_v(5, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, exp_addr(a, 0), 1'b0);
    push_v(5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    push_v(5, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, exp_addr(a, 1), 1'b0);
    run_vecs();
    @(negedge clk);
    check("t5 stall before reset", 128'(stall), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("t5 stall in reset",     128'(stall),   128'(0));
    check("t5 mem_req in reset",   128'(mem_req), 128'(0));
    check("t5 fill_we in reset",   128'(fill_we), 128'(0));
    check("t5 fill_data in reset", fill_data,     128'(0));
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    check("t5 stray rvalid stall",   128'(stall),   128'(0));
    check("t5 stray rvalid mem_req", 128'(mem_req), 128'(0));
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("t5 after stray stall", 128'(stall), 128'(0));
    @(posedge clk);
    #1;
    add_refill(5, 32'h0000_1230, 32'hE0, 8'h23, 20'h00001, -1, 0, 1'b1);
    run_vecs();

    // 6: back-to-back misses, the second sampled in the IDLE cycle right after FILL.
    add_refill(6, 32'h0000_1230, 32'hA0, 8'h23, 20'h00001, -1, 0, 1'b0);
    add_refill(6, 32'h0000_2000, 32'hB0, 8'h00, 20'h00002, -1, 0, 1'b1);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
